// File: rtl/rvv_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rvv_clk_rst_seq
// Brief    : Multi-channel clock-enable / reset sequencer with staggered
//            ascending reset release. Optional quiesce phase before a software
//            re-reset is enabled by defining RVV_CLK_RST_QUIESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_clk_rst_seq #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int QUIESCE_CYCLES = 4
) (
  input  logic              io_aclk,
  input  logic              io_aresetn,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] clk_run_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic              busy_o,
  output logic              done_o
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int c_rel_last_int = (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int c_cnt_max      = max3(HOLD_CYCLES, c_rel_last_int + 1, QUIESCE_CYCLES);
  localparam int c_cnt_w        = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rel_last  = c_cnt_w'(c_rel_last_int);
`ifdef RVV_CLK_RST_QUIESCE_EN
  localparam logic [c_cnt_w-1:0] c_qui_last  = c_cnt_w'(QUIESCE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3
`ifdef RVV_CLK_RST_QUIESCE_EN
    ,
    ST_QUIESCE = 3'd4
`endif
  } state_t;

  logic                r_sync1;
  logic                r_rst_sync_n;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [NUM_CH-1:0]   w_rst_n_nxt;
  logic [NUM_CH-1:0]   w_clk_en_nxt;

  // Two-flop reset synchroniser: asynchronous assert, synchronous release.
  always_ff @(posedge io_aclk or negedge io_aresetn) begin
    if (!io_aresetn) begin
      r_sync1      <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_sync1      <= 1'b1;
      r_rst_sync_n <= r_sync1;
    end
  end

  always_ff @(posedge io_aclk or negedge io_aresetn) begin
    if (!io_aresetn) begin
      r_state  <= ST_SYNC;
      r_cnt    <= '0;
      rst_n_o  <= '0;
      clk_en_o <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      rst_n_o  <= w_rst_n_nxt;
      clk_en_o <= w_clk_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      // Leave SYNC on the same edge that raises the synchronised reset.
      ST_SYNC: begin
        if (r_sync1 | r_rst_sync_n) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end
      end
      ST_ASSERT: begin
        if (sw_rst_req_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_hold_last) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (sw_rst_req_i) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_rel_last) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (sw_rst_req_i) begin
`ifdef RVV_CLK_RST_QUIESCE_EN
          w_state_nxt = ST_QUIESCE;
`else
          w_state_nxt = ST_ASSERT;
`endif
          w_cnt_nxt   = '0;
        end
      end
`ifdef RVV_CLK_RST_QUIESCE_EN
      ST_QUIESCE: begin
        if (r_cnt == c_qui_last) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_SYNC;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops carry them glitch-free.
  always_comb begin
    w_rst_n_nxt  = '0;
    w_clk_en_nxt = '0;
    case (w_state_nxt)
      ST_ASSERT: begin
        w_clk_en_nxt = '1;
      end
      ST_RELEASE: begin
        w_clk_en_nxt = '1;
        for (int k = 0; k < NUM_CH; k++) begin
          w_rst_n_nxt[k] = ((k * STAGGER_CYCLES) <= int'(w_cnt_nxt));
        end
      end
      ST_RUN: begin
        w_rst_n_nxt  = '1;
        w_clk_en_nxt = (r_state == ST_RUN) ? clk_run_i : '1;
      end
`ifdef RVV_CLK_RST_QUIESCE_EN
      ST_QUIESCE: begin
        w_rst_n_nxt = '1;
      end
`endif
      default: begin
        w_rst_n_nxt  = '0;
        w_clk_en_nxt = '0;
      end
    endcase
  end

  assign busy_o = (r_state != ST_RUN);
  assign done_o = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: doc/rvv_clk_rst_seq.md
Name: rvv_clk_rst_seq

Overview:
- Synthesizable multi-channel clock-enable and reset sequencer for the RVV core subsystem.
- Replaces ad-hoc bench clock start/stop and reset pulses with a deterministic hardware sequence.
- Per domain: holds reset with clocks running, releases resets in staggered ascending order, then hands clock enables to software run controls.
- Supports software-requested re-reset without a global io_aresetn pulse.

Parameters:
- NUM_CH, 4: number of clock/reset domains; legal range 1..16.
- HOLD_CYCLES, 16: cycles all resets stay asserted with clocks enabled; must be >= 1.
- STAGGER_CYCLES, 4: cycles between successive channel releases; must be >= 1.
- QUIESCE_CYCLES, 4: clock-gated cycles before re-reset; used only with the optional feature; must be >= 1.

Ports:
- io_aclk  in  1  single clock; all flops are on its rising edge.
- io_aresetn  in  1  asynchronous active-low reset.
- sw_rst_req_i  in  1  single-cycle pulse requesting a full re-sequence.
- clk_run_i  in  NUM_CH  per-channel software clock run request; honoured only in RUN.
- rst_n_o  out  NUM_CH  per-channel active-low reset; registered.
- clk_en_o  out  NUM_CH  per-channel clock enable for downstream ICGs; registered.
- busy_o  out  1  high whenever state is not RUN.
- done_o  out  1  high in RUN.

Behaviour:
- Reset synchroniser:
  - io_aresetn feeds a 2-flop synchroniser.
  - Assertion is asynchronous: all flops reset immediately.
  - Deassertion is synchronous: rst_sync_n goes high on the 2nd rising edge after io_aresetn rises.
- Values while io_aresetn is low:
  - rst_n_o = 0, clk_en_o = 0, busy_o = 1, done_o = 0.
  - State = SYNC, counter = 0.
- State machine: SYNC -> ASSERT -> RELEASE -> RUN, plus QUIESCE (optional feature only).
- SYNC:
  - Waits for rst_sync_n.
  - Moves to ASSERT on the edge where rst_sync_n is 1; call this edge T0.
- ASSERT:
  - clk_en_o = all 1, rst_n_o = all 0.
  - Counter increments each cycle.
  - After HOLD_CYCLES cycles, moves to RELEASE; the counter clears.
- RELEASE:
  - rst_n_o[k] rises at T0+HOLD_CYCLES+k*STAGGER_CYCLES, for k = 0..NUM_CH-1.
  - Once a channel is released it stays high.
  - clk_en_o stays all 1.
  - Moves to RUN one cycle after the last channel is released.
  - Default timing: ch0 at T0+16, ch3 at T0+28, done_o=1 from T0+29.
- RUN:
  - clk_en_o[i] <= clk_run_i[i], with 1-cycle latency.
  - rst_n_o = all 1; busy_o = 0; done_o = 1.
- sw_rst_req_i handling:
  - In RUN: moves to ASSERT, or to QUIESCE if the optional feature is enabled.
  - In ASSERT: restarts the hold counter at 0.
  - In RELEASE: the next edge drives all rst_n_o = 0, returns to ASSERT and sets the counter to 0.
  - In SYNC: ignored.
- Counter width: $clog2(max(HOLD_CYCLES, (NUM_CH-1)*STAGGER_CYCLES+1, QUIESCE_CYCLES)+1). No wrap is reachable.
- When NUM_CH=1, RELEASE lasts exactly 1 cycle.
- io_aresetn asserted mid-sequence: every output takes its reset value asynchronously and the state returns to SYNC, regardless of state.
- rst_n_o and clk_en_o never glitch: both are driven directly from flops.

Optional Feature:
- Macro: RVV_CLK_RST_QUIESCE_EN.
- Defined:
  - sw_rst_req_i in RUN enters QUIESCE.
  - In QUIESCE: clk_en_o = all 0 and rst_n_o = all 1, held for QUIESCE_CYCLES cycles.
  - QUIESCE then moves to ASSERT. rst_n_o falls on the same edge that clk_en_o returns to all 1.
  - In QUIESCE, a further sw_rst_req_i is ignored.
- Undefined:
  - QUIESCE state and its logic are absent.
  - sw_rst_req_i in RUN drives rst_n_o = all 0 on the next edge, with clk_en_o unchanged (all 1 in ASSERT).
  - QUIESCE_CYCLES is unused.

Test Plan (defaults):
1. Power-on release:
   - Stimulus: release io_aresetn.
   - Response: T0 = 2nd edge; clk_en_o = 4'hF from T0; rst_n_o = 4'b0001 @T0+16, 4'b0011 @T0+20, 4'b0111 @T0+24, 4'b1111 @T0+28; done_o=1 and busy_o=0 @T0+29.
2. Run control:
   - Stimulus: in RUN, clk_run_i = 4'b1010.
   - Response: clk_en_o = 4'b1010 one cycle later; rst_n_o stays 4'hF.
3. Re-reset from RUN (macro undefined):
   - Stimulus: sw_rst_req_i pulse.
   - Response: next edge rst_n_o = 0 and clk_en_o = 4'hF; the release sequence repeats with identical offsets relative to that edge.
4. Re-reset from RUN (macro defined):
   - Stimulus: sw_rst_req_i pulse.
   - Response: clk_en_o = 0 for 4 cycles with rst_n_o = 4'hF; then rst_n_o = 0 and clk_en_o = 4'hF; the full sequence follows.
5. Request during sequencing:
   - Stimulus: sw_rst_req_i at T0+22, when rst_n_o = 4'b0011.
   - Response: rst_n_o = 0 at T0+23; ch0 re-releases at T0+23+16.
6. Async reset mid-RELEASE:
   - Stimulus: drop io_aresetn between edges at T0+25.
   - Response: rst_n_o = 0, clk_en_o = 0, busy_o = 1 immediately, with no clock edge; clean restart after release.
